vend_fsm_param: RTL and testbench
=================================

# vend_fsm_param

Parametrised successor of the three-drink coffee controller: a credit-accumulating vending FSM for `NUM_PROD` products with per-product prices, coin saturation, purchase denial and optional change return. It sits between the coin/keypad front-end and the dispenser actuators. It serves coin-operated drink panels of any product count without RTL edits.

## Interface
- `NUM_PROD`, 3: number of selectable products.
- `CREDIT_W`, 6: credit register width. One unit equals 0.05.
- `MAX_CREDIT`, 40: upper credit limit in units. Must be < 2^CREDIT_W.
- `PRICE_VEC`, {6'd4,6'd3,6'd2}: packed prices, `NUM_PROD*CREDIT_W` bits. Product k uses slice k.
- `SEL_W`, $clog2(NUM_PROD+1): selection width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `c05` in 1: 0.05 coin strobe, adds 1 unit.
- `c10` in 1: 0.10 coin strobe, adds 2 units.
- `sel` in SEL_W: 0 means no request. Value k selects product k-1.
- `vend` out NUM_PROD: one-hot dispense pulse.
- `deny` out 1: one-cycle pulse on a selection with insufficient credit.
- `coin_reject` out 1: one-cycle pulse when a coin is refused.
- `chg05` out 1: change-coin pulse for 0.05.
- `chg10` out 1: change-coin pulse for 0.10.
- `credit` out CREDIT_W: current credit in units.
- `state_reg` out 3: FSM state, for debug.

## Operation
- State encoding: IDLE=0, CREDIT=1, VEND=2, CHANGE=3.
- Coin value each cycle is c05 + 2·c10. Both strobes high in the same cycle adds 3 units.
- IDLE:
  - credit = 0.
  - A coin loads credit and moves the FSM to CREDIT.
  - `sel` is ignored.
- CREDIT, coin present:
  - If credit+coin ≤ MAX_CREDIT, add it.
  - Otherwise assert `coin_reject` and leave credit unchanged.
- CREDIT, `sel`=k≠0:
  - Out-of-range k (k > NUM_PROD) behaves as a denial.
  - If credit ≥ price, go to VEND. A coin arriving in the same cycle is accepted first. The comparison uses the pre-coin credit.
  - If credit < price, pulse `deny` and stay in CREDIT.
- VEND, exactly one cycle:
  - `vend[k-1]`=1 and credit -= price.
  - Coins in VEND are refused with `coin_reject`.
- CHANGE:
  - Emit one coin per cycle: `chg10` while remainder ≥ 2, otherwise `chg05`.
  - Decrement credit by 2 or 1 for each coin emitted.
  - When credit reaches 0, go to IDLE.
  - Coins in CHANGE are refused with `coin_reject`. `sel` is ignored.
- All arithmetic is unsigned, CREDIT_W bits. The saturation check guarantees no overflow.
- Reset mid-operation clears credit and drops the FSM to IDLE. Pending change is forfeited.

## Timing
- All outputs are registered. Every output is 0 in reset and in IDLE.
- Coin to credit update: 1 cycle.
- `sel` sampled at cycle N gives the `vend` pulse at N+1 and the first change coin at N+2.
- `deny` and `coin_reject` appear one cycle after the causing input.
- `sel` is level-sampled. It must be released before the FSM returns to CREDIT or IDLE, otherwise it re-triggers.

## Configuration
- `VEND_CHANGE_EN` defined:
  - VEND with nonzero remainder goes to CHANGE; zero remainder goes to IDLE.
- `VEND_CHANGE_EN` undefined:
  - CHANGE state, `chg05` and `chg10` logic are removed. `chg05` and `chg10` are tied to 0.
  - VEND goes to CREDIT if remainder > 0 (credit retained for the next purchase), otherwise to IDLE.

## Structure
- Package `vend_pkg`: state enum/localparams (IDLE, CREDIT, VEND, CHANGE), coin unit constants `COIN05_U`=1 and `COIN10_U`=2, and the price-slice extraction function.
- Sub-module `vend_change_dispenser` holds the CHANGE-state coin splitter: remainder in, coin pulses out, done flag. It is instantiated only under `VEND_CHANGE_EN`.
- Top level contains the FSM, credit register and price mux.

## Test plan
- Reset then c05 ×2 and `sel`=1 → credit 1, 2; `vend`=3'b001 for one cycle; credit 0; back to IDLE.
- c10 ×2 (credit 4) and `sel`=3 → `vend`=3'b100, credit 0, IDLE.
- c05 once and `sel`=2 → `deny` pulse; credit stays 1; state stays CREDIT.
- Coins to credit 39, then c10 → `coin_reject`, credit 39. A further c05 → credit 40.
- `VEND_CHANGE_EN` set, credit 7 and `sel`=1 → `vend`[0], remainder 5 → `chg10`, `chg10`, `chg05` on consecutive cycles, then IDLE. With the macro off, the same stimulus leaves credit 5 in CREDIT.
- c05 and c10 together → credit +3. `reset` asserted during CHANGE → next cycle credit 0, `state_reg`=0, no change pulses.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM states, coin unit values and price-slice lookup for vend_fsm_param.
package vend_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CREDIT = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3
  } state_e;
  localparam int COIN05_U = 1;
  localparam int COIN10_U = 2;
  localparam int PRICE_MAX_W = 256;
  // Price vectors are zero-extended to PRICE_MAX_W so one function serves every NUM_PROD/CREDIT_W.
  function automatic logic [31:0] price_slice(input logic [PRICE_MAX_W-1:0] vec, input int idx, input int w);
    return 32'(vec >> (idx * w)) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: turns the remaining change into one registered 0.10/0.05 coin pulse per cycle.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] rem,
  output logic         chg05,
  output logic         chg10,
  output logic         done
);
  logic chg05_q, chg05_d, chg10_q, chg10_d;
  always_comb begin
    chg10_d = en && rem >= W'(COIN10_U);
    chg05_d = en && rem == W'(COIN05_U);
  end
  always_ff @(posedge clock) begin
    chg05_q <= reset ? 1'b0 : chg05_d;
    chg10_q <= reset ? 1'b0 : chg10_d;
  end
  assign done  = rem == '0;
  assign chg05 = chg05_q;
  assign chg10 = chg10_q;
endmodule

// File: rtl/vend_fsm_param.sv
// vend_fsm_param: credit-accumulating vending FSM for NUM_PROD products with saturation and denial.
// Define VEND_CHANGE_EN to return leftover credit as change coins instead of keeping it.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int NUM_PROD = 3,
  parameter int CREDIT_W = 6,
  parameter int MAX_CREDIT = 40,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_VEC = {6'd4, 6'd3, 6'd2},
  parameter int SEL_W = $clog2(NUM_PROD + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                c05,
  input  logic                c10,
  input  logic [SEL_W-1:0]    sel,
  output logic [NUM_PROD-1:0] vend,
  output logic                deny,
  output logic                coin_reject,
  output logic                chg05,
  output logic                chg10,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          state_reg
);
  state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, price_q, price_d, coin, price_sel, rem;
  logic [CREDIT_W:0] sum;
  logic [NUM_PROD-1:0] vend_q, vend_d;
  logic deny_q, deny_d, rej_q, rej_d, coin_in, fits, sel_ok;
  assign coin_in   = c05 | c10;
  assign coin      = CREDIT_W'((c05 ? COIN05_U : 0) + (c10 ? COIN10_U : 0));
  assign sum       = {1'b0, credit_q} + {1'b0, coin};
  assign fits      = sum <= (CREDIT_W + 1)'(MAX_CREDIT);
  assign sel_ok    = sel != '0 && sel <= SEL_W'(NUM_PROD);
  assign price_sel = sel_ok ? CREDIT_W'(price_slice(PRICE_MAX_W'(PRICE_VEC), 32'(sel - SEL_W'(1)), CREDIT_W)) : '0;
  // In VEND the remainder after purchase; in CHANGE the remainder after the coin now being paid out.
  assign rem = state_q == VEND ? credit_q - price_q
             : credit_q - (credit_q >= CREDIT_W'(COIN10_U) ? CREDIT_W'(COIN10_U) : CREDIT_W'(COIN05_U));
`ifdef VEND_CHANGE_EN
  logic done;
  vend_change_dispenser #(.W(CREDIT_W)) u_disp (
    .clock(clock),
    .reset(reset),
    .en   (state_q == VEND || state_q == CHANGE),
    .rem  (rem),
    .chg05(chg05),
    .chg10(chg10),
    .done (done)
  );
`else
  assign chg05 = 1'b0;
  assign chg10 = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    vend_d   = '0;
    deny_d   = 1'b0;
    rej_d    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d  = coin_in ? CREDIT : IDLE;
        credit_d = coin;
      end
      CREDIT: begin
        credit_d = coin_in && fits ? sum[CREDIT_W-1:0] : credit_q;
        rej_d    = coin_in && !fits;
        if (sel != '0) begin
          if (sel_ok && credit_q >= price_sel) begin
            state_d = VEND;
            price_d = price_sel;
            vend_d  = NUM_PROD'(1) << (sel - SEL_W'(1));
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      VEND: begin
        rej_d    = coin_in;
        credit_d = rem;
`ifdef VEND_CHANGE_EN
        state_d  = done ? IDLE : CHANGE;
`else
        state_d  = rem == '0 ? IDLE : CREDIT;
`endif
      end
`ifdef VEND_CHANGE_EN
      CHANGE: begin
        rej_d    = coin_in;
        credit_d = rem;
        state_d  = done ? IDLE : CHANGE;
      end
`endif
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      price_q  <= '0;
      vend_q   <= '0;
      deny_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      vend_q   <= vend_d;
      deny_q   <= deny_d;
      rej_q    <= rej_d;
    end
  end
  assign vend        = vend_q;
  assign deny        = deny_q;
  assign coin_reject = rej_q;
  assign credit      = credit_q;
  assign state_reg   = state_q;
endmodule

// File: tb/tb_vend_fsm_param.sv
// tb_vend_fsm_param: scoreboard bench for vend_fsm_param; expectations follow VEND_CHANGE_EN when defined.
module tb_vend_fsm_param;
  typedef struct packed {
    logic [2:0] st;
    logic [5:0] cr;
    logic [2:0] vd;
    logic       dn, rj, h5, h10;
  } obs_t;
  typedef struct packed {
    logic       rst, c05, c10;
    logic [1:0] sel;
    obs_t       exp;
  } row_t;
  localparam logic [2:0] ID = 3'd0, CR = 3'd1, VN = 3'd2, CH = 3'd3;
  localparam logic [4:0] N = 5'b00000, RS = 5'b10000, C5 = 5'b01000, C10 = 5'b00100, CB = 5'b01100;
  localparam logic [4:0] S1 = 5'b00001, S2 = 5'b00010, S3 = 5'b00011;
  localparam logic [3:0] NF = 4'b0000, DN = 4'b1000, RJ = 4'b0100, H5 = 4'b0010, H10 = 4'b0001;
  logic clock = 1'b0, reset = 1'b1, c05 = 1'b0, c10 = 1'b0;
  logic [1:0] sel = '0;
  logic [2:0] vend, state_reg;
  logic deny, coin_reject, chg05, chg10;
  logic [5:0] credit;
  obs_t obs;
  obs_t exp_q[$];
  int checks = 0, errors = 0;
  vend_fsm_param dut (
    .clock(clock), .reset(reset), .c05(c05), .c10(c10), .sel(sel),
    .vend(vend), .deny(deny), .coin_reject(coin_reject), .chg05(chg05), .chg10(chg10),
    .credit(credit), .state_reg(state_reg)
  );
  assign obs = {state_reg, credit, vend, deny, coin_reject, chg05, chg10};
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end
  function automatic row_t r(logic [4:0] in, logic [2:0] st, int cr, logic [2:0] vd, logic [3:0] fl);
    return {in, st, 6'(cr), vd, fl};
  endfunction
  task automatic drive(input row_t x);
    reset = x.rst;
    c05   = x.c05;
    c10   = x.c10;
    sel   = x.sel;
    exp_q.push_back(x.exp);
  endtask
  task automatic test_reset();
    row_t rows[$];
    obs_t e;
    rows = '{r(RS | C10, ID, 0, 0, NF), r(RS, ID, 0, 0, NF), r(N, ID, 0, 0, NF),
             r(S1, ID, 0, 0, NF), r(S3, ID, 0, 0, NF)};
    foreach (rows[i]) begin
      drive(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset row %0d: got %p expected %p", i, obs, e); end
    end
  endtask
  task automatic test_buy();
    row_t rows[$];
    obs_t e;
    rows = '{r(C5, CR, 1, 0, NF), r(C5, CR, 2, 0, NF), r(S1, VN, 2, 3'b001, NF), r(N, ID, 0, 0, NF),
             r(C10, CR, 2, 0, NF), r(C10, CR, 4, 0, NF), r(S3, VN, 4, 3'b100, NF), r(N, ID, 0, 0, NF)};
    foreach (rows[i]) begin
      drive(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL buy row %0d: got %p expected %p", i, obs, e); end
    end
  endtask
  task automatic test_deny();
    row_t rows[$];
    obs_t e;
    rows = '{r(C5, CR, 1, 0, NF), r(S2, CR, 1, 0, DN), r(N, CR, 1, 0, NF),
             r(C5 | S1, CR, 2, 0, DN), r(S1, VN, 2, 3'b001, NF), r(N, ID, 0, 0, NF)};
    foreach (rows[i]) begin
      drive(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL deny row %0d: got %p expected %p", i, obs, e); end
    end
  endtask
  task automatic test_saturation();
    row_t rows[$];
    obs_t e;
    for (int k = 1; k <= 19; k++) rows.push_back(r(C10, CR, 2 * k, 0, NF));
    rows.push_back(r(C5, CR, 39, 0, NF));
    rows.push_back(r(C10, CR, 39, 0, RJ));
    rows.push_back(r(C5, CR, 40, 0, NF));
    rows.push_back(r(C5, CR, 40, 0, RJ));
    rows.push_back(r(CB, CR, 40, 0, RJ));
    rows.push_back(r(S3, VN, 40, 3'b100, NF));
`ifdef VEND_CHANGE_EN
    rows.push_back(r(C5, CH, 36, 0, RJ | H10));
`else
    rows.push_back(r(C5, CR, 36, 0, RJ));
`endif
    rows.push_back(r(RS, ID, 0, 0, NF));
    foreach (rows[i]) begin
      drive(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL saturation row %0d: got %p expected %p", i, obs, e); end
    end
  endtask
  task automatic test_both_coins();
    row_t rows[$];
    obs_t e;
    rows = '{r(N, ID, 0, 0, NF), r(CB, CR, 3, 0, NF), r(CB, CR, 6, 0, NF), r(RS, ID, 0, 0, NF)};
    foreach (rows[i]) begin
      drive(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL both_coins row %0d: got %p expected %p", i, obs, e); end
    end
  endtask
  task automatic test_change();
    row_t rows[$];
    obs_t e;
    rows = '{r(N, ID, 0, 0, NF), r(C10, CR, 2, 0, NF), r(C10, CR, 4, 0, NF), r(C10, CR, 6, 0, NF),
             r(C5, CR, 7, 0, NF), r(S1, VN, 7, 3'b001, NF)};
`ifdef VEND_CHANGE_EN
    rows.push_back(r(N, CH, 5, 0, H10));
    rows.push_back(r(N, CH, 3, 0, H10));
    rows.push_back(r(N, CH, 1, 0, H5));
    rows.push_back(r(N, ID, 0, 0, NF));
`else
    rows.push_back(r(N, CR, 5, 0, NF));
    rows.push_back(r(S2, VN, 5, 3'b010, NF));
    rows.push_back(r(N, CR, 2, 0, NF));
    rows.push_back(r(S1, VN, 2, 3'b001, NF));
    rows.push_back(r(N, ID, 0, 0, NF));
`endif
    foreach (rows[i]) begin
      drive(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL change row %0d: got %p expected %p", i, obs, e); end
    end
  endtask
  task automatic test_reset_mid();
    row_t rows[$];
    obs_t e;
`ifdef VEND_CHANGE_EN
    rows = '{r(C10, CR, 2, 0, NF), r(C10, CR, 4, 0, NF), r(C10, CR, 6, 0, NF), r(S1, VN, 6, 3'b001, NF),
             r(N, CH, 4, 0, H10), r(RS | C5, ID, 0, 0, NF), r(N, ID, 0, 0, NF)};
`else
    rows = '{r(C10, CR, 2, 0, NF), r(C5, CR, 3, 0, NF), r(RS | C5, ID, 0, 0, NF), r(N, ID, 0, 0, NF)};
`endif
    foreach (rows[i]) begin
      drive(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_mid row %0d: got %p expected %p", i, obs, e); end
    end
  endtask
  initial begin
    test_reset();
    test_buy();
    test_deny();
    test_saturation();
    test_both_coins();
    test_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
